obi_mem_responder: RTL and testbench

- OBI slave endpoint: the responder side of the OBI master ports the CGRA drives into the external bus.
- Terminates OBI requests into a word-addressed local SRAM model with configurable read latency and grant wait-states.
- Used as the external-xbar slave target in CGRA/X-HEEP system benches.
- Also usable as a synthesizable scratchpad behind an ext_bus slave port.

---
 rtl/obi_mem_responder.sv | 126 ++++++++++++
 tb/tb_obi_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// OBI responder terminating requests into a word-addressed local memory, with
// a fixed-latency in-order response pipeline and programmable grant wait-states.
module obi_mem_responder #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [31:0] OOR_PATTERN = 32'hBADC_AB1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic [3:0]  stall_cycles_i,
  output logic [2:0]  outstanding_o,
  output logic [15:0] oor_count_o
);

  localparam int unsigned AW   = $clog2(NUM_WORDS);
  localparam logic [2:0]  LAT  = 3'(RD_LATENCY);
  localparam logic [32:0] SPAN = 33'(NUM_WORDS) << 2;

  logic [31:0] mem [NUM_WORDS];

  logic [31:0]   offset;
  logic          inRange;
  logic [AW-1:0] wordIdx;
  logic          unusedBits;
  logic          accept;
  logic [31:0]   respData;

  logic [3:0]  stallCnt_q, stallCnt_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic [15:0] oorCount_q, oorCount_d;
  logic [RD_LATENCY-1:0]       vld_q, vld_d;
  logic [RD_LATENCY-1:0][31:0] dat_q, dat_d;

  // Unsigned wrap-around makes addresses below the base land far out of range.
  assign offset     = addr_i - BASE_ADDR;
  assign inRange    = {1'b0, offset} < SPAN;
  assign wordIdx    = offset[AW+1:2];
  assign unusedBits = ^offset[1:0];

  assign rvalid_o      = vld_q[RD_LATENCY-1];
  assign rdata_o       = dat_q[RD_LATENCY-1];
  assign outstanding_o = outstanding_q;
  assign oor_count_o   = oorCount_q;

  assign gnt_o  = req_i & ~rst_i & (stallCnt_q == 4'd0) &
                  ((outstanding_q < LAT) | rvalid_o);
  assign accept = gnt_o;

  always_comb begin
    respData = 32'd0;
    if (!we_i) begin
      respData = inRange ? mem[wordIdx] : OOR_PATTERN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && we_i && inRange) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[wordIdx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    stallCnt_d    = stallCnt_q;
    outstanding_d = outstanding_q;
    oorCount_d    = oorCount_q;
    vld_d         = '0;
    dat_d         = dat_q;

    if (accept) begin
      stallCnt_d = stall_cycles_i;
    end else if (stallCnt_q != 4'd0) begin
      stallCnt_d = stallCnt_q - 4'd1;
    end

    if (accept && !rvalid_o) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!accept && rvalid_o) begin
      outstanding_d = outstanding_q - 3'd1;
    end

    if (accept && !inRange && oorCount_q != 16'hFFFF) begin
      oorCount_d = oorCount_q + 16'd1;
    end

    vld_d[0] = accept;
    dat_d[0] = respData;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    // The output stage only loads on a valid response so rdata_o holds between pulses.
    if (!vld_d[RD_LATENCY-1]) begin
      dat_d[RD_LATENCY-1] = dat_q[RD_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q    <= 4'd0;
      outstanding_q <= 3'd0;
      oorCount_q    <= 16'd0;
      vld_q         <= '0;
      dat_q         <= '0;
    end else begin
      stallCnt_q    <= stallCnt_d;
      outstanding_q <= outstanding_d;
      oorCount_q    <= oorCount_d;
      vld_q         <= vld_d;
      dat_q         <= dat_d;
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench: three responder instances with read latencies 1, 3 and 2
// share one clock and are exercised one after another.
module tb_obi_mem_responder;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk;
  logic        rst [3];
  logic        req [3];
  logic        we [3];
  logic [3:0]  be [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  stall [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] rdata [3];
  logic [2:0]  outstanding [3];
  logic [15:0] oorCount [3];

  int compared;
  int mismatched;

  int expOut [9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
  int expVld [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gUnit
    obi_mem_responder #(
      .NUM_WORDS  (16),
      .BASE_ADDR  (BASE),
      .RD_LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 2)),
      .OOR_PATTERN(32'hBADC_AB1E)
    ) dut (
      .clk_i         (clk),
      .rst_i         (rst[g]),
      .req_i         (req[g]),
      .we_i          (we[g]),
      .be_i          (be[g]),
      .addr_i        (addr[g]),
      .wdata_i       (wdata[g]),
      .gnt_o         (gnt[g]),
      .rvalid_o      (rvalid[g]),
      .rdata_o       (rdata[g]),
      .stall_cycles_i(stall[g]),
      .outstanding_o (outstanding[g]),
      .oor_count_o   (oorCount[g])
    );
  end

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int u, input logic r, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    req[u]   = r;
    we[u]    = w;
    addr[u]  = a;
    be[u]    = b;
    wdata[u] = d;
    #1;
  endtask

  task automatic waitGrant(input int u, input string tag);
    int n = 0;
    while (!gnt[u] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(tag, {31'd0, gnt[u]}, 32'd1);
  endtask

  task automatic doWrite(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    applyStimulus(u, 1'b1, 1'b1, a, b, d);
    waitGrant(u, "writeGrant");
    applyStimulus(u, 1'b0, 1'b0, a, 4'h0, 32'd0);
  endtask

  task automatic doRead(input int u, input logic [31:0] a, input logic [31:0] exp,
                        input int lat, input string tag);
    int n = 1;
    applyStimulus(u, 1'b1, 1'b0, a, 4'hF, 32'd0);
    waitGrant(u, "readGrant");
    applyStimulus(u, 1'b0, 1'b0, a, 4'h0, 32'd0);
    while (!rvalid[u] && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_lat"}, n, lat);
    checkOutput({tag, "_data"}, rdata[u], exp);
  endtask

  task automatic drain(input int u);
    int n = 0;
    while (outstanding[u] != 3'd0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain", {29'd0, outstanding[u]}, 32'd0);
  endtask

  task automatic resetUnit(input int u);
    @(negedge clk);
    rst[u]  = 1'b1;
    req[u]  = 1'b1;
    we[u]   = 1'b0;
    addr[u] = BASE;
    #1;
    checkOutput("rstGnt", {31'd0, gnt[u]}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rstGnt2", {31'd0, gnt[u]}, 32'd0);
    checkOutput("rstRvalid", {31'd0, rvalid[u]}, 32'd0);
    checkOutput("rstRdata", rdata[u], 32'd0);
    checkOutput("rstOutstanding", {29'd0, outstanding[u]}, 32'd0);
    checkOutput("rstOor", {16'd0, oorCount[u]}, 32'd0);
    @(negedge clk);
    rst[u] = 1'b0;
    req[u] = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0;
      addr[i] = BASE; wdata[i] = 32'd0; stall[i] = 4'd0;
    end

    // Latency 1: full write then read, consecutive grants.
    resetUnit(0);
    applyStimulus(0, 1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    checkOutput("t1WrGnt", {31'd0, gnt[0]}, 32'd1);
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'd0);
    checkOutput("t1RdGnt", {31'd0, gnt[0]}, 32'd1);
    checkOutput("t1WrRvalid", {31'd0, rvalid[0]}, 32'd1);
    checkOutput("t1WrRdata", rdata[0], 32'd0);
    checkOutput("t1Outst", {29'd0, outstanding[0]}, 32'd1);
    applyStimulus(0, 1'b0, 1'b0, BASE, 4'h0, 32'd0);
    checkOutput("t1RdRvalid", {31'd0, rvalid[0]}, 32'd1);
    checkOutput("t1RdRdata", rdata[0], 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 1'b0, BASE, 4'h0, 32'd0);
    checkOutput("t1Idle", {31'd0, rvalid[0]}, 32'd0);
    checkOutput("t1Hold", rdata[0], 32'hDEAD_BEEF);
    checkOutput("t1OutstIdle", {29'd0, outstanding[0]}, 32'd0);

    // Byte-lane write merges into the existing word.
    doWrite(0, BASE + 32'h10, 32'h1122_3344, 4'b0101);
    doRead(0, BASE + 32'h10, 32'hDE22_BE44, 1, "t2");

    // Two wait-states: grants three cycles apart, responses likewise.
    stall[0] = 4'd2;
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'd0);
    checkOutput("t4Gnt0", {31'd0, gnt[0]}, 32'd1);
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'd0);
    checkOutput("t4Gnt1", {31'd0, gnt[0]}, 32'd0);
    checkOutput("t4Rv1", {31'd0, rvalid[0]}, 32'd1);
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'd0);
    checkOutput("t4Gnt2", {31'd0, gnt[0]}, 32'd0);
    checkOutput("t4Rv2", {31'd0, rvalid[0]}, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'd0);
    checkOutput("t4Gnt3", {31'd0, gnt[0]}, 32'd1);
    checkOutput("t4Rv3", {31'd0, rvalid[0]}, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, BASE, 4'h0, 32'd0);
    checkOutput("t4Rv4", {31'd0, rvalid[0]}, 32'd1);
    checkOutput("t4Data", rdata[0], 32'hDE22_BE44);
    stall[0] = 4'd0;
    repeat (3) applyStimulus(0, 1'b0, 1'b0, BASE, 4'h0, 32'd0);

    // Out-of-range read below base and write just past the top.
    doWrite(0, BASE, 32'hCAFE_F00D, 4'hF);
    applyStimulus(0, 1'b1, 1'b0, BASE - 32'd4, 4'hF, 32'd0);
    checkOutput("t5RdGnt", {31'd0, gnt[0]}, 32'd1);
    applyStimulus(0, 1'b1, 1'b1, BASE + 32'd64, 4'hF, 32'h1234_5678);
    checkOutput("t5WrGnt", {31'd0, gnt[0]}, 32'd1);
    checkOutput("t5OorData", rdata[0], 32'hBADC_AB1E);
    applyStimulus(0, 1'b0, 1'b0, BASE, 4'h0, 32'd0);
    checkOutput("t5WrRv", {31'd0, rvalid[0]}, 32'd1);
    checkOutput("t5WrData", rdata[0], 32'd0);
    checkOutput("t5OorCount", {16'd0, oorCount[0]}, 32'd2);
    doRead(0, BASE, 32'hCAFE_F00D, 1, "t5Word0");
    checkOutput("t5OorCount2", {16'd0, oorCount[0]}, 32'd2);

    // Latency 3, request held high for five back-to-back reads.
    resetUnit(1);
    for (int k = 0; k < 5; k++) begin
      doWrite(1, BASE + 32'(4 * k), 32'h1000_0000 + 32'(k), 4'hF);
    end
    drain(1);
    for (int t = 0; t < 9; t++) begin
      if (t < 5) begin
        applyStimulus(1, 1'b1, 1'b0, BASE + 32'(4 * t), 4'hF, 32'd0);
        checkOutput($sformatf("t3Gnt%0d", t), {31'd0, gnt[1]}, 32'd1);
      end else begin
        applyStimulus(1, 1'b0, 1'b0, BASE, 4'h0, 32'd0);
      end
      checkOutput($sformatf("t3Outst%0d", t), {29'd0, outstanding[1]}, 32'(expOut[t]));
      checkOutput($sformatf("t3Rv%0d", t), {31'd0, rvalid[1]}, 32'(expVld[t]));
      if (expVld[t] == 1) begin
        checkOutput($sformatf("t3Data%0d", t), rdata[1], 32'h1000_0000 + 32'(t - 3));
      end
    end

    // Latency 2, reset with two reads in flight.
    resetUnit(2);
    doWrite(2, BASE + 32'hC, 32'h600D_F00D, 4'hF);
    drain(2);
    applyStimulus(2, 1'b1, 1'b0, BASE + 32'hC, 4'hF, 32'd0);
    checkOutput("t6Gnt0", {31'd0, gnt[2]}, 32'd1);
    applyStimulus(2, 1'b1, 1'b0, BASE + 32'hC, 4'hF, 32'd0);
    checkOutput("t6Gnt1", {31'd0, gnt[2]}, 32'd1);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    checkOutput("t6RstGnt", {31'd0, gnt[2]}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("t6RstGnt2", {31'd0, gnt[2]}, 32'd0);
    checkOutput("t6RstRv", {31'd0, rvalid[2]}, 32'd0);
    checkOutput("t6RstOutst", {29'd0, outstanding[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    req[2] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      applyStimulus(2, 1'b0, 1'b0, BASE, 4'h0, 32'd0);
      checkOutput($sformatf("t6NoRv%0d", t), {31'd0, rvalid[2]}, 32'd0);
    end
    doRead(2, BASE + 32'hC, 32'h600D_F00D, 2, "t6Persist");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
